// File: rtl/temp_conv_scheduler.sv
// Round-robin scheduler sharing one temperature-to-ADC converter among N_CH setpoint channels.
// Each grant clamps the channel temperature, restarts the converter, waits out its latency and stores the code.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no conversion in flight; converter released from reset
// GRANT   | pick next requester from rr_ptr, clamp and latch its setpoint
// LOAD    | converter held in reset for one cycle with the new temperature
// WAIT    | converter settling, counter runs 0..SETTLE-1
// CAPTURE | store converter code for sel, pulse ack/range_err next cycle
module temp_conv_scheduler #(
   parameter int N_CH     = 4,
   parameter int SETTLE   = 24,
   parameter int TEMP_MIN = -55,
   parameter int TEMP_MAX = 299
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH-1:0]          req,
   input  logic [12*N_CH-1:0]       req_temp,
   output logic [N_CH-1:0]          ack,
   output logic                     range_err,
   output logic [12*N_CH-1:0]       adc_out,
   output logic [N_CH-1:0]          adc_valid,
   output logic                     busy,
   output logic signed [11:0]       conv_temp,
   output logic                     conv_rst,
   input  logic [11:0]              conv_adc
);

   localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW = $clog2(SETTLE);
   localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE - 1);
   localparam logic [SW-1:0]     CH_LAST  = SW'(N_CH - 1);
   localparam logic signed [11:0] T_MIN   = 12'(TEMP_MIN);
   localparam logic signed [11:0] T_MAX   = 12'(TEMP_MAX);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GRANT   = 3'd1,
      S_LOAD    = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        sel_q, sel_d;
   logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic signed [11:0]   conv_temp_q, conv_temp_d;
   logic                 clamp_q, clamp_d;
   logic                 conv_rst_q, conv_rst_d;
   logic [N_CH-1:0]      ack_q, ack_d;
   logic                 range_err_q, range_err_d;
   logic [12*N_CH-1:0]   adc_out_q, adc_out_d;
   logic [N_CH-1:0]      adc_valid_q, adc_valid_d;

   logic [SW-1:0]        pick, pick_hi, pick_lo;
   logic                 found_hi;
   logic signed [11:0]   temp_raw, temp_clamped;
   logic                 clamp_hit;

   // Lowest set request at or above rr_ptr wins; otherwise wrap to the lowest set request.
   always_comb begin
      pick_hi  = '0;
      pick_lo  = '0;
      found_hi = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            pick_lo = SW'(i);
            if (SW'(i) >= rr_ptr_q) begin
               pick_hi  = SW'(i);
               found_hi = 1'b1;
            end
         end
      end
      pick = found_hi ? pick_hi : pick_lo;
   end

   always_comb begin
      temp_raw = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (SW'(i) == pick) begin
            temp_raw = req_temp[12*i +: 12];
         end
      end
      temp_clamped = temp_raw;
      clamp_hit    = 1'b0;
      if (temp_raw < T_MIN) begin
         temp_clamped = T_MIN;
         clamp_hit    = 1'b1;
      end else if (temp_raw > T_MAX) begin
         temp_clamped = T_MAX;
         clamp_hit    = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      conv_temp_d = conv_temp_q;
      clamp_d     = clamp_q;
      conv_rst_d  = 1'b0;
      ack_d       = '0;
      range_err_d = 1'b0;
      adc_out_d   = adc_out_q;
      adc_valid_d = adc_valid_q;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (|req) begin
               sel_d       = pick;
               conv_temp_d = temp_clamped;
               clamp_d     = clamp_hit;
               conv_rst_d  = 1'b1;
               state_d     = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            for (int i = 0; i < N_CH; i++) begin
               if (SW'(i) == sel_q) begin
                  adc_out_d[12*i +: 12] = conv_adc;
                  adc_valid_d[i]        = 1'b1;
                  ack_d[i]              = 1'b1;
               end
            end
            range_err_d = clamp_q;
            rr_ptr_d    = (sel_q == CH_LAST) ? '0 : sel_q + 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         conv_temp_q <= '0;
         clamp_q     <= 1'b0;
         conv_rst_q  <= 1'b1;
         ack_q       <= '0;
         range_err_q <= 1'b0;
         adc_out_q   <= '0;
         adc_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         conv_temp_q <= conv_temp_d;
         clamp_q     <= clamp_d;
         conv_rst_q  <= conv_rst_d;
         ack_q       <= ack_d;
         range_err_q <= range_err_d;
         adc_out_q   <= adc_out_d;
         adc_valid_q <= adc_valid_d;
      end
   end

   assign ack       = ack_q;
   assign range_err = range_err_q;
   assign adc_out   = adc_out_q;
   assign adc_valid = adc_valid_q;
   assign busy      = (state_q != S_IDLE);
   assign conv_temp = conv_temp_q;
   assign conv_rst  = conv_rst_q;

endmodule

// File: tb/tb_temp_conv_scheduler.sv
// Bench for temp_conv_scheduler: converter model with settle latency, round-robin and clamp reference model.
module tb_temp_conv_scheduler;

   localparam int N      = 4;
   localparam int SETTLE = 24;
   localparam int LAT    = SETTLE + 4;
   localparam int CONV_LAT = 23;

   logic                clk;
   logic                reset;
   logic [N-1:0]        req;
   logic [12*N-1:0]     req_temp;
   logic [N-1:0]        ack;
   logic                range_err;
   logic [12*N-1:0]     adc_out;
   logic [N-1:0]        adc_valid;
   logic                busy;
   logic signed [11:0]  conv_temp;
   logic                conv_rst;
   logic [11:0]         conv_adc;

   int errors = 0;
   int checks = 0;
   int model_ptr = 0;
   int settle_cnt = 0;

   temp_conv_scheduler #(.N_CH(N), .SETTLE(SETTLE), .TEMP_MIN(-55), .TEMP_MAX(299)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_temp  (req_temp),
      .ack       (ack),
      .range_err (range_err),
      .adc_out   (adc_out),
      .adc_valid (adc_valid),
      .busy      (busy),
      .conv_temp (conv_temp),
      .conv_rst  (conv_rst),
      .conv_adc  (conv_adc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int clamp_t(input int t);
      if (t < -55) return -55;
      if (t > 299) return 299;
      return t;
   endfunction

   function automatic logic [11:0] adc_of(input int t);
      return 12'((t + 55) * 11 + 100);
   endfunction

   // Converter: code is garbage until CONV_LAT cycles after its reset drops.
   always @(posedge clk) begin
      if (conv_rst) settle_cnt <= 0;
      else if (settle_cnt < 1000) settle_cnt <= settle_cnt + 1;
   end
   assign conv_adc = (settle_cnt >= CONV_LAT) ? adc_of(int'(conv_temp)) : 12'hFFF;

   task automatic set_temp(input int ch, input int t);
      req_temp[12*ch +: 12] = 12'(t);
   endtask

   function automatic logic [11:0] adc_ch(input int ch);
      return adc_out[12*ch +: 12];
   endfunction

   task automatic wait_ack(input int limit, output int ch, output int cyc);
      ch  = -1;
      cyc = 0;
      while (ch < 0 && cyc < limit) begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < N; k++) if (ack[k]) ch = k;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req = '0;
      req_temp = '0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (ack !== '0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL rst_range_err: got %b want 0", range_err); end
      checks++; if (adc_out !== '0) begin errors++; $display("FAIL rst_adc_out: got %h want 0", adc_out); end
      checks++; if (adc_valid !== '0) begin errors++; $display("FAIL rst_adc_valid: got %b want 0", adc_valid); end
      checks++; if (conv_rst !== 1'b1) begin errors++; $display("FAIL rst_conv_rst: got %b want 1", conv_rst); end
      checks++; if (conv_temp !== '0) begin errors++; $display("FAIL rst_conv_temp: got %0d want 0", conv_temp); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (conv_rst !== 1'b0) begin errors++; $display("FAIL idle_conv_rst: got %b want 0", conv_rst); end
      model_ptr = 0;
   endtask

   task automatic test_single();
      int ch, cyc;
      set_temp(0, 25);
      req[0] = 1'b1;
      wait_ack(LAT + 10, ch, cyc);
      checks++; if (ch !== 0) begin errors++; $display("FAIL single_ch: got %0d want 0", ch); end
      checks++; if (cyc !== LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", cyc, LAT); end
      checks++; if (adc_ch(0) !== adc_of(25)) begin errors++; $display("FAIL single_adc: got %h want %h", adc_ch(0), adc_of(25)); end
      checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL single_range_err: got %b want 0", range_err); end
      checks++; if (adc_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b want 0001", adc_valid); end
      req[0] = 1'b0;
      model_ptr = 1;
      @(negedge clk);
      checks++; if (ack !== '0) begin errors++; $display("FAIL single_ack_pulse: got %b want 0", ack); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_round_robin();
      int ch, cyc;
      int temps[N];
      int order[5] = '{0, 1, 2, 3, 0};
      set_temp(3, 0);
      req[3] = 1'b1;
      wait_ack(LAT + 10, ch, cyc);
      checks++; if (ch !== 3) begin errors++; $display("FAIL rr_pre_ch: got %0d want 3", ch); end
      req[3] = 1'b0;
      model_ptr = 0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         temps[i] = int'($urandom_range(0, 300)) - 50;
         set_temp(i, temps[i]);
      end
      req = '1;
      for (int k = 0; k < 5; k++) begin
         wait_ack(LAT + 10, ch, cyc);
         checks++;
         if (ack !== 4'(1 << order[k]) || cyc !== LAT) begin
            errors++;
            $display("FAIL rr_order_%0d: got ack=%b after %0d cycles want ack=%b after %0d", k, ack, cyc, 4'(1 << order[k]), LAT);
         end
         if (ch >= 0) begin
            checks++;
            if (adc_ch(ch) !== adc_of(clamp_t(temps[ch]))) begin
               errors++;
               $display("FAIL rr_adc_%0d: got %h want %h", k, adc_ch(ch), adc_of(clamp_t(temps[ch])));
            end
            if (k != 0) req[ch] = 1'b0;
            model_ptr = (ch + 1) % N;
         end
      end
      req = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_clamp();
      int tv[6] = '{-100, 400, 299, -55, -2048, 2047};
      int ch, cyc, c, exp_t;
      for (int i = 0; i < 6; i++) begin
         c = i % N;
         exp_t = clamp_t(tv[i]);
         set_temp(c, tv[i]);
         req[c] = 1'b1;
         repeat (6) @(negedge clk);
         checks++;
         if (int'(conv_temp) !== exp_t) begin errors++; $display("FAIL clamp_conv_temp_%0d: got %0d want %0d", tv[i], conv_temp, exp_t); end
         wait_ack(LAT + 10, ch, cyc);
         checks++;
         if (ch !== c || cyc + 6 !== LAT) begin errors++; $display("FAIL clamp_ack_%0d: got ch=%0d at %0d want ch=%0d at %0d", tv[i], ch, cyc + 6, c, LAT); end
         checks++;
         if (range_err !== (exp_t != tv[i])) begin errors++; $display("FAIL clamp_range_err_%0d: got %b want %b", tv[i], range_err, exp_t != tv[i]); end
         checks++;
         if (adc_ch(c) !== adc_of(exp_t)) begin errors++; $display("FAIL clamp_adc_%0d: got %h want %h", tv[i], adc_ch(c), adc_of(exp_t)); end
         req[c] = 1'b0;
         model_ptr = (c + 1) % N;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_sample_hold();
      int ch, cyc;
      set_temp(1, 100);
      req[1] = 1'b1;
      repeat (10) @(negedge clk);
      set_temp(1, 200);
      wait_ack(LAT + 10, ch, cyc);
      checks++;
      if (ch !== 1 || cyc + 10 !== LAT) begin errors++; $display("FAIL hold_ack: got ch=%0d at %0d want ch=1 at %0d", ch, cyc + 10, LAT); end
      checks++;
      if (adc_ch(1) !== adc_of(100)) begin errors++; $display("FAIL hold_adc_first: got %h want %h", adc_ch(1), adc_of(100)); end
      req[1] = 1'b0;
      @(negedge clk);
      req[1] = 1'b1;
      wait_ack(LAT + 10, ch, cyc);
      checks++;
      if (adc_ch(1) !== adc_of(200)) begin errors++; $display("FAIL hold_adc_second: got %h want %h", adc_ch(1), adc_of(200)); end
      req[1] = 1'b0;
      model_ptr = 2;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int ch, cyc;
      logic seen;
      set_temp(2, 150);
      req[2] = 1'b1;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || ack !== '0 || range_err !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got busy=%b ack=%b range_err=%b want 0", busy, ack, range_err); end
      checks++; if (adc_valid !== '0 || adc_out !== '0) begin errors++; $display("FAIL mid_rst_data: got valid=%b adc=%h want 0", adc_valid, adc_out); end
      checks++; if (conv_rst !== 1'b1 || conv_temp !== '0) begin errors++; $display("FAIL mid_rst_conv: got rst=%b temp=%0d want 1/0", conv_rst, conv_temp); end
      req = '0;
      model_ptr = 0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (LAT + 5) begin
         @(negedge clk);
         if (ack != '0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_ack: got ack seen=%b want 0", seen); end
      req[2] = 1'b1;
      wait_ack(LAT + 10, ch, cyc);
      checks++;
      if (ch !== 2 || cyc !== LAT) begin errors++; $display("FAIL mid_retry_ack: got ch=%0d at %0d want ch=2 at %0d", ch, cyc, LAT); end
      checks++;
      if (adc_ch(2) !== adc_of(150) || adc_valid !== 4'b0100) begin errors++; $display("FAIL mid_retry_data: got adc=%h valid=%b want %h 0100", adc_ch(2), adc_valid, adc_of(150)); end
      req[2] = 1'b0;
      model_ptr = 3;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_pulse();
      logic seen;
      set_temp(3, 50);
      req[3] = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pulse_busy_grant: got %b want 1", busy); end
      req[3] = 1'b0;
      seen = 1'b0;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (ack != '0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL pulse_no_ack: got ack seen=%b want 0", seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pulse_busy_idle: got %b want 0", busy); end
      checks++; if (adc_valid !== 4'b0100) begin errors++; $display("FAIL pulse_valid: got %b want 0100", adc_valid); end
   endtask

   task automatic test_random();
      int ch, cyc, exp_ch, c;
      int temps[N];
      logic [N-1:0] pend;
      for (int it = 0; it < 8; it++) begin
         pend = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) temps[i] = int'($urandom_range(0, 4095)) - 2048;
            else temps[i] = int'($urandom_range(0, 400)) - 80;
            set_temp(i, temps[i]);
         end
         req = pend;
         for (int n = 0; n < N && pend != '0; n++) begin
            exp_ch = -1;
            for (int k = N - 1; k >= 0; k--) begin
               c = (model_ptr + k) % N;
               if (pend[c]) exp_ch = c;
            end
            wait_ack(LAT + 10, ch, cyc);
            checks++;
            if (ch !== exp_ch || cyc !== LAT) begin errors++; $display("FAIL rand_ack_%0d: got ch=%0d at %0d want ch=%0d at %0d", it, ch, cyc, exp_ch, LAT); end
            checks++;
            if (adc_ch(exp_ch) !== adc_of(clamp_t(temps[exp_ch])) || range_err !== (clamp_t(temps[exp_ch]) != temps[exp_ch])) begin
               errors++;
               $display("FAIL rand_data_%0d: got adc=%h err=%b want adc=%h temp=%0d", it, adc_ch(exp_ch), range_err, adc_of(clamp_t(temps[exp_ch])), temps[exp_ch]);
            end
            pend[exp_ch] = 1'b0;
            req[exp_ch] = 1'b0;
            model_ptr = (exp_ch + 1) % N;
         end
         req = '0;
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      req = '0;
      req_temp = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_clamp();
      test_sample_hold();
      test_reset_mid();
      test_pulse();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
